// File: rtl/bandai2003_pkg.sv
// Shared definitions for the Bandai 2003 cartridge mapper unlock sequence:
// unlock address constants, frame geometry, default key, host FSM states
// and the frame validity rule.
package bandai2003_pkg;

  // Unlock address sequence driven by the console, and the lock-released marker
  localparam logic [7:0] ADDR_UNLOCK_ACK    = 8'h5A;
  localparam logic [7:0] ADDR_UNLOCK_NAK    = 8'hA5;
  localparam logic [7:0] ADDR_LOCK_RELEASED = 8'hFF;

  // Serial frame returned by the cartridge: start bit, 16-bit payload, stop bit
  localparam int          FRAME_LEN   = 18;
  localparam logic [15:0] DEFAULT_KEY = 16'h28A0;

  // Host sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_CREL  = 3'd2,
    ST_ACK   = 3'd3,
    ST_NAK   = 3'd4,
    ST_RECV  = 3'd5,
    ST_CHECK = 3'd6
  } auth_state_e;

  // A frame is valid when both framing bits are low and the payload matches the key
  function automatic logic frame_ok(input logic [FRAME_LEN-1:0] frame,
                                    input logic [15:0]          key);
    return (frame[0] == 1'b0) &&
           (frame[FRAME_LEN-1] == 1'b0) &&
           (frame[FRAME_LEN-2:1] == key);
  endfunction

endpackage

// File: rtl/cart_so_deser.sv
// LSB-first deserialiser for the cartridge serial output. While enabled it
// shifts one bit per cycle into the top of an 18-bit register, so the first
// bit received ends up in bit 0. frame_full marks that the last enabled
// cycle completed a whole frame.
module cart_so_deser
  import bandai2003_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 en_i,
  input  logic                 so_i,
  output logic [FRAME_LEN-1:0] frame_o,
  output logic                 frame_full_o
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);

  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic                 full_q, full_d;

  // Shift/count next-state: hold when disabled, shift and count when enabled
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    full_d    = full_q;
    if (en_i) begin
      shreg_d = {so_i, shreg_q[FRAME_LEN-1:1]};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = 5'd0;
        full_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        full_d    = 1'b0;
      end
    end else begin
      full_d = full_q;
    end
  end

  // Deserialiser state registers; an idle bus reads as all ones
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bit_cnt_q <= 5'd0;
      shreg_q   <= {FRAME_LEN{1'b1}};
      full_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      full_q    <= full_d;
    end
  end

  assign frame_o      = shreg_q;
  assign frame_full_o = full_q;

endmodule

// File: rtl/cart_auth_host.sv
// Console-side host for the Bandai 2003 cartridge unlock handshake.
// Resets the cartridge, drives the 0x5A / 0xA5 unlock addresses, receives
// the 18-bit answer frame and records the result in SYSTEM_CTRL1[7].
// Optional feature macro: CART_AUTH_RETRY_EN (retry invalid frames up to
// MAX_TRIES attempts). Without it a run is always a single attempt.
// All outputs are registered; their next values are decoded from the
// FSM's next state so that each output is valid during the state itself.
module cart_auth_host
  import bandai2003_pkg::*;
#(
  parameter int          RST_CYCLES = 4,
  parameter logic [15:0] KEY        = DEFAULT_KEY,
  parameter logic [7:0]  IDLE_ADDR  = 8'h00,
  parameter int          MAX_TRIES  = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       start,
  input  logic       so,
  output logic       cart_rstn,
  output logic [7:0] cart_addr,
  output logic       bus_own,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic       unlocked,
  output logic [1:0] tries
);

`ifdef CART_AUTH_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  // Phase counter is shared by the cartridge-reset and receive phases
  localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [7:0] RECV_LAST = 8'(FRAME_LEN - 1);
  localparam logic [1:0] TRY_LIMIT = 2'(MAX_TRIES);

  auth_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        cart_rstn_q, cart_rstn_d;
  logic [7:0]  cart_addr_q, cart_addr_d;
  logic        bus_own_q, bus_own_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        unlocked_q, unlocked_d;
  logic [1:0]  tries_q, tries_d;

  logic [FRAME_LEN-1:0] frame_s;
  logic                 frame_full_s;
  logic                 frame_valid_s;
  logic                 retry_s;
  logic                 recv_en_s;

  assign recv_en_s = (state_q == ST_RECV);

  cart_so_deser u_deser (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .en_i         (recv_en_s),
    .so_i         (so),
    .frame_o      (frame_s),
    .frame_full_o (frame_full_s)
  );

  assign frame_valid_s = frame_full_s && frame_ok(frame_s, KEY);
  assign retry_s       = RETRY_EN && (tries_q < TRY_LIMIT);

  // Sequencer next state, phase counter and result bookkeeping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    unlocked_d = unlocked_q;
    tries_d    = tries_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Resetting the cartridge re-locks it, so the old result goes away
          state_d    = ST_CRST;
          cnt_d      = 8'd0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          unlocked_d = 1'b0;
          tries_d    = 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_CREL;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CREL: state_d = ST_ACK;
      ST_ACK:  state_d = ST_NAK;
      ST_NAK: begin
        state_d = ST_RECV;
        cnt_d   = 8'd0;
      end
      ST_RECV: begin
        if (cnt_q == RECV_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        if (frame_valid_s) begin
          state_d    = ST_IDLE;
          pass_d     = 1'b1;
          unlocked_d = 1'b1;
          done_d     = 1'b1;
        end else if (retry_s) begin
          state_d = ST_CRST;
          cnt_d   = 8'd0;
          tries_d = tries_q + 2'd1;
        end else begin
          state_d = ST_IDLE;
          fail_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Bus-facing outputs decoded from the state being entered
  always_comb begin
    cart_rstn_d = (state_d != ST_CRST);
    bus_own_d   = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_ACK:  cart_addr_d = ADDR_UNLOCK_ACK;
      ST_NAK:  cart_addr_d = ADDR_UNLOCK_NAK;
      default: cart_addr_d = IDLE_ADDR;
    endcase
  end

  // State, counter and output registers; reset holds the cartridge in reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      cart_rstn_q <= 1'b0;
      cart_addr_q <= IDLE_ADDR;
      bus_own_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      unlocked_q  <= 1'b0;
      tries_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cart_rstn_q <= cart_rstn_d;
      cart_addr_q <= cart_addr_d;
      bus_own_q   <= bus_own_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      unlocked_q  <= unlocked_d;
      tries_q     <= tries_d;
    end
  end

  assign cart_rstn = cart_rstn_q;
  assign cart_addr = cart_addr_q;
  assign bus_own   = bus_own_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign unlocked  = unlocked_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_cart_auth_host.sv
// Testbench for cart_auth_host: a behavioural cartridge mapper answers the
// unlock sequence, a reference model predicts each run's completion cycle
// and result, and a monitor compares every done pulse against a scoreboard.
module tb_cart_auth_host;

  localparam int          RST_CYCLES  = 4;
  localparam logic [15:0] KEY         = 16'h28A0;
  localparam logic [7:0]  IDLE_ADDR   = 8'h00;
  localparam int          MAX_TRIES   = 3;
  localparam int          ATTEMPT_LEN = RST_CYCLES + 22;
  localparam logic [17:0] GOOD_FRAME  = {1'b0, KEY, 1'b0};
  localparam logic [17:0] NO_CART     = 18'h3FFFF;
`ifdef CART_AUTH_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       start = 1'b0;
  logic       so = 1'b1;
  logic       cart_rstn;
  logic [7:0] cart_addr;
  logic       bus_own, busy, done, pass, fail, unlocked;
  logic [1:0] tries;

  cart_auth_host #(
    .RST_CYCLES (RST_CYCLES),
    .KEY        (KEY),
    .IDLE_ADDR  (IDLE_ADDR),
    .MAX_TRIES  (MAX_TRIES)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .start     (start),
    .so        (so),
    .cart_rstn (cart_rstn),
    .cart_addr (cart_addr),
    .bus_own   (bus_own),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .unlocked  (unlocked),
    .tries     (tries)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         done_cyc;
    bit         pass;
    bit         fail;
    logic [1:0] tries;
  } exp_t;

  exp_t        sb_q[$];
  logic [17:0] cart_q[$];
  bit          cart_present = 1'b1;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Cartridge mapper model: latch 0x5A, then on 0xA5 load the frame and
  // shift it out LSB-first, one bit per cycle; idle high otherwise.
  initial begin : cart_model
    logic [7:0]  a;
    logic        r;
    logic [17:0] shf;
    int          idx;
    bit          armed;
    armed = 1'b0;
    idx   = 18;
    shf   = NO_CART;
    forever begin
      @(negedge CLK);
      a = cart_addr;
      r = cart_rstn;
      @(posedge CLK);
      #1;
      if (!r || !RSTn) begin
        armed = 1'b0;
        idx   = 18;
        so    = 1'b1;
      end else begin
        if (idx < 18) begin
          idx++;
          so = (idx < 18 && cart_present) ? shf[idx] : 1'b1;
        end
        if (a == 8'h5A) begin
          armed = 1'b1;
        end else if (a == 8'hA5 && armed) begin
          armed = 1'b0;
          shf   = (cart_q.size() > 0) ? cart_q.pop_front() : GOOD_FRAME;
          idx   = 0;
          so    = cart_present ? shf[0] : 1'b1;
        end else begin
          armed = 1'b0;
        end
      end
    end
  end

  // Reference model: walk the attempts the cartridge will answer with
  function automatic exp_t predict(input int s, input logic [17:0] frames[$]);
    exp_t        e;
    logic [17:0] f;
    int          k;
    bit          ok;
    k = 0;
    e.pass = 1'b0;
    e.fail = 1'b0;
    forever begin
      f  = (k < frames.size()) ? frames[k] : GOOD_FRAME;
      k++;
      ok = (f[0] == 1'b0) && (f[17] == 1'b0) && (f[16:1] == KEY);
      if (ok) begin
        e.pass = 1'b1;
        break;
      end
      if (!RETRY || k >= MAX_TRIES) begin
        e.fail = 1'b1;
        break;
      end
    end
    e.done_cyc = s + ATTEMPT_LEN * k + 1;
    e.tries    = 2'(k);
    return e;
  endfunction

  // Issue one start pulse; returns the cycle in which start was high
  task automatic issue_run(input logic [17:0] frames[$], input bit present, output int s);
    @(posedge CLK);
    #1;
    start = 1'b1;
    s = cyc;
    cart_present = present;
    cart_q = frames;
    sb_q.push_back(predict(s, frames));
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge CLK);
    #1;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cart_rstn"}, cart_rstn, 1'b0);
    check({tag, "_cart_addr"}, cart_addr, IDLE_ADDR);
    check({tag, "_bus_own"}, bus_own, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_fail"}, fail, 1'b0);
    check({tag, "_unlocked"}, unlocked, 1'b0);
    check({tag, "_tries"}, tries, 2'd0);
  endtask

  // Monitor: every done pulse (or a predicted one that fails to appear)
  // is compared with the oldest scoreboard entry
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0 && (done === 1'b1 || sb_q[0].done_cyc == cyc)) begin
        e = sb_q.pop_front();
        check("done_pulse", done, 1'b1);
        check("done_cycle", cyc, e.done_cyc);
        check("pass", pass, e.pass);
        check("fail", fail, e.fail);
        check("unlocked", unlocked, e.pass);
        check("tries", tries, e.tries);
      end else if (done !== 1'b0) begin
        check("spurious_done", done, 1'b0);
      end
    end
  end

  initial begin : stimulus
    logic [17:0] fl[$];
    logic [17:0] f;
    int          s;
    int          s2;
    int          bitpos;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("rst");
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    check("rel_cart_rstn", cart_rstn, 1'b1);
    check("rel_busy", busy, 1'b0);

    // Good cartridge with cycle-level bus checks
    fl = '{GOOD_FRAME};
    issue_run(fl, 1'b1, s);
    at_cycle(s + 1);
    check("crst_cart_rstn", cart_rstn, 1'b0);
    check("crst_bus_own", bus_own, 1'b1);
    check("crst_busy", busy, 1'b1);
    at_cycle(s + RST_CYCLES);
    check("crst_end_cart_rstn", cart_rstn, 1'b0);
    at_cycle(s + RST_CYCLES + 1);
    check("crel_cart_rstn", cart_rstn, 1'b1);
    check("crel_addr", cart_addr, IDLE_ADDR);
    at_cycle(s + RST_CYCLES + 2);
    check("ack_addr", cart_addr, 8'h5A);
    at_cycle(s + RST_CYCLES + 3);
    check("nak_addr", cart_addr, 8'hA5);
    at_cycle(s + RST_CYCLES + 4);
    check("recv_addr", cart_addr, IDLE_ADDR);
    drain();
    @(negedge CLK);
    check("idle_busy", busy, 1'b0);
    check("idle_bus_own", bus_own, 1'b0);
    check("sticky_unlocked", unlocked, 1'b1);

    // No cartridge: serial line stays high
    fl = '{NO_CART, NO_CART, NO_CART};
    issue_run(fl, 1'b0, s);
    drain();

    // Wrong payload on every attempt
    fl = '{{1'b0, 16'h28A1, 1'b0}, {1'b0, 16'h28A1, 1'b0}, {1'b0, 16'h28A1, 1'b0}};
    issue_run(fl, 1'b1, s);
    drain();

    // First attempt bad, second good
    fl = '{{1'b0, 16'h28A1, 1'b0}, GOOD_FRAME};
    issue_run(fl, 1'b1, s);
    drain();

    // Reset pulse during RECV cycle 10
    fl = '{GOOD_FRAME};
    issue_run(fl, 1'b1, s);
    at_cycle(s + RST_CYCLES + 13);
    @(posedge CLK);
    #1;
    RSTn = 1'b0;
    sb_q.delete();
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_rel_cart_rstn", cart_rstn, 1'b1);
    issue_run(fl, 1'b1, s);
    drain();

    // start re-pulsed mid-run is ignored; start in the done cycle is taken
    fl = '{GOOD_FRAME};
    issue_run(fl, 1'b1, s);
    at_cycle(s + 2);
    pulse_start();
    at_cycle(s + 19);
    pulse_start();
    at_cycle(s + ATTEMPT_LEN);
    issue_run(fl, 1'b1, s2);
    check("restart_in_done_cycle", s2, s + ATTEMPT_LEN + 1);
    at_cycle(s2 + 1);
    check("restart_unlocked_cleared", unlocked, 1'b0);
    check("restart_busy", busy, 1'b1);
    check("restart_tries", tries, 2'd1);
    drain();

    // Randomised cartridge answers
    for (int r = 0; r < 16; r++) begin
      fl.delete();
      for (int k = 0; k < MAX_TRIES; k++) begin
        f = GOOD_FRAME;
        case ($urandom_range(0, 3))
          0, 1: f = GOOD_FRAME;
          2: begin
            bitpos = $urandom_range(0, 17);
            f[bitpos] = ~f[bitpos];
          end
          default: f = 18'($urandom);
        endcase
        fl.push_back(f);
      end
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      issue_run(fl, 1'b1, s);
      drain();
    end

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
